serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine. Time-multiplexes one full-adder cell across WIDTH operand bits, LSB first.
- A carry flip-flop links the bits from one cycle to the next.
- Sits between a requester, using a start/busy handshake, and a consumer, using a valid/ready handshake.
- Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op_sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- carryin  input  1  add carry-in; sampled with start; ignored when op_sub=1
- busy  output  1  high in RUN and DONE
- result_valid  output  1  high in DONE
- result_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result; stable while result_valid=1
- carryout  output  1  final carry; for subtract, 1 = no borrow
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation):
  - state=IDLE; busy, result_valid, sum, carryout, overflow all 0.
  - Internal shift registers, carry flop and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - Load shift_a=a; shift_b = op_sub ? ~b : b.
  - Load carry = op_sub ? 1 : carryin.
  - Set bit counter to 0; go to RUN.
  - start=0 stays in IDLE.
- RUN: each edge processes one bit:
  - Cell computes {c,s} = shift_a[0] + shift_b[0] + carry.
  - s shifts into sum from the MSB end; shift_a and shift_b shift right; carry <= c.
  - On the edge processing bit WIDTH-1:
    - record overflow = carry(in) XOR c;
    - carryout <= c;
    - go to DONE.
  - start is ignored in RUN.
- DONE: result_valid=1 and sum/carryout/overflow are held.
  - On an edge with result_ready=1, go to IDLE; result_valid drops the next cycle.
  - sum, carryout and overflow keep their last values in IDLE until the next accept.
  - start is ignored in DONE, including the handoff cycle. Back-to-back requests need one IDLE cycle.
- Latency:
  - Accept edge T; result_valid is high after edge T+WIDTH.
  - Minimum start-to-start period is WIDTH+2 cycles.
- Arithmetic: modulo 2^WIDTH. Bit counter is clog2(WIDTH) bits and never wraps inside RUN.
- result_ready=1 outside DONE has no effect. Inputs a, b, op_sub and carryin may change freely after the accept edge.

Decomposition:
- Shared package:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - OP_ADD=1'b0 / OP_SUB=1'b1.
- Sub-module: one instance of the team's existing behavioralFullAdder as the single-bit cell.
- FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, add 8'h0F + 8'h01, carryin=0 -> sum=8'h10, carryout=0, overflow=0; result_valid rises exactly 8 cycles after the accept edge.
- Add 8'hFF + 8'h01, carryin=1 -> sum=8'h01, carryout=1, overflow=0. Add 8'h7F + 8'h01, carryin=0 -> sum=8'h80, carryout=0, overflow=1.
- Sub 8'h05 - 8'h07 (carryin=1, must be ignored) -> sum=8'hFE, carryout=0, overflow=0. Sub 8'h80 - 8'h01 -> sum=8'h7F, carryout=1, overflow=1.
- Pulse start with different operands during RUN and DONE, holding result_ready=0 for 5 cycles:
  - the original result is held unchanged and busy stays 1;
  - after result_ready=1, busy and result_valid are 0 the next cycle.
- Assert reset on the 3rd RUN cycle -> next cycle state=IDLE, busy=0, result_valid=0, sum=0; a fresh start then completes correctly.
- result_ready tied high with start asserted continuously -> results spaced every WIDTH+2 cycles, each correct, none dropped.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract engine.
//   - FSM state encodings (2-bit, kept as plain constants so older
//     code that compares raw state values keeps working)
//   - operation select encodings for op_sub
package serial_adder_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell, shared across all operand bits by the
// serial engine.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out
module behavioralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine. One full-adder cell processes the
// operands LSB first, one bit per clock, with a carry flop linking bits.
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   start, op_sub, a, b,
//   carryin                - request and operands, sampled in IDLE only
//   busy                   - high while an operation is running or held
//   result_valid,
//   result_ready           - result handshake to the consumer
//   sum, carryout,
//   overflow               - result, final carry, signed overflow
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_a, shift_b, sum_q;
  logic             carry, carryout_q, overflow_q;
  logic [CW-1:0]    cnt;
  logic             s, c;

  behavioralFullAdder u_fa (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .sum  (s),
    .cout (c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_a    <= '0;
      shift_b    <= '0;
      sum_q      <= '0;
      carry      <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b and force the carry-in.
            shift_a <= a;
            shift_b <= (op_sub == OP_SUB) ? ~b : b;
            carry   <= (op_sub == OP_SUB) ? 1'b1 : carryin;
            cnt     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Result bits enter at the MSB; after WIDTH shifts the first
          // bit computed sits at bit 0.
          sum_q   <= {s, sum_q[WIDTH-1:1]};
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry   <= c;
          if (cnt == LAST) begin
            // carry here is the carry into the MSB, c the carry out of it.
            overflow_q <= carry ^ c;
            carryout_q <= c;
            cnt        <= '0;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (result_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);
  assign sum          = sum_q;
  assign carryout     = carryout_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, op_sub, carryin, result_ready;
  logic [W-1:0] a, b;
  logic         busy, result_valid, carryout, overflow;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_sub       (op_sub),
    .a            (a),
    .b            (b),
    .carryin      (carryin),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .carryout     (carryout),
    .overflow     (overflow)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] es;
    logic         ec, eo;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: two's-complement arithmetic on integers.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sub,
                       input logic cin, output logic [W-1:0] s, output logic co, output logic ov);
    int unsigned full;
    int sa, sb, sr;
    sa = $signed(ma);
    sb = $signed(mb);
    if (sub) begin
      full = int'(ma) + (256 - int'(mb));
      sr   = sa - sb;
    end else begin
      full = int'(ma) + int'(mb) + int'(cin);
      sr   = sa + sb + int'(cin);
    end
    s  = full[W-1:0];
    co = full[W];
    ov = (sr > 127) || (sr < -128);
  endtask

  // Issue one operation from IDLE, measure latency, return results, accept.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic icin, input string nm, output logic [W-1:0] rs,
                       output logic rc, output logic ro);
    int lat;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; op_sub = isub; carryin = icin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); carryin = 1'($urandom);
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, W);
    rs = sum; rc = carryout; ro = overflow;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({nm, " idle busy/valid"}, {busy, result_valid}, 2'b00);
  endtask

  logic [W-1:0] rs, es, hs;
  logic rc, ro, ec, eo, hc, ho;

  initial begin
    tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; op_sub = 1'b0; carryin = 1'b0;
    result_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy, result_valid, sum, carryout, overflow}, '0);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, $sformatf("vec%0d", i), rs, rc, ro);
      chk($sformatf("vec%0d result", i), {rs, rc, ro}, {tbl[i].es, tbl[i].ec, tbl[i].eo});
    end

    // Random operations against the model.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      logic rsub, rcin;
      ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom); rcin = 1'($urandom);
      model(ra, rb, rsub, rcin, es, ec, eo);
      do_op(ra, rb, rsub, rcin, $sformatf("rnd%0d", i), rs, rc, ro);
      chk($sformatf("rnd%0d result", i), {rs, rc, ro}, {es, ec, eo});
    end

    // start pulses during RUN and DONE must be ignored; result held.
    begin
      int lat;
      model(8'h33, 8'h44, 1'b0, 1'b1, es, ec, eo);
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; op_sub = 1'b0; carryin = 1'b1;
      @(negedge clk);
      a = 8'hAA; b = 8'h11; op_sub = 1'b1;   // start still high during RUN
      lat = 0;
      while (!result_valid && lat < 20) begin
        @(negedge clk);
        lat++;
        start = 1'($urandom);
      end
      chk("hold latency", lat, W);
      hs = sum; hc = carryout; ho = overflow;
      chk("hold first result", {hs, hc, ho}, {es, ec, eo});
      for (int k = 0; k < 5; k++) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        chk($sformatf("hold cyc%0d", k), {busy, result_valid, sum, carryout, overflow},
            {2'b11, es, ec, eo});
      end
      start = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("hold release", {busy, result_valid}, 2'b00);
      chk("hold kept in idle", {sum, carryout, overflow}, {es, ec, eo});
    end

    // Reset on the third RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; op_sub = 1'b0; carryin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset", {busy, result_valid, sum, carryout, overflow}, '0);
    do_op(8'h12, 8'h34, 1'b1, 1'b0, "post reset", rs, rc, ro);
    model(8'h12, 8'h34, 1'b1, 1'b0, es, ec, eo);
    chk("post reset result", {rs, rc, ro}, {es, ec, eo});

    // Back-to-back: start and result_ready held high; one accept
    // every W+2 cycles.
    begin
      logic [W-1:0] qs[$];
      logic         qc[$], qo[$];
      int last, got;
      last = -1; got = 0;
      result_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 0; cyc < 6 * (W + 2); cyc++) begin
        if (result_valid) begin
          if (qs.size() == 0) begin
            chk("b2b unexpected result", 1, 0);
          end else begin
            chk($sformatf("b2b result%0d", got), {sum, carryout, overflow},
                {qs.pop_front(), qc.pop_front(), qo.pop_front()});
            if (last >= 0) chk($sformatf("b2b spacing%0d", got), cyc - last, W + 2);
          end
          last = cyc;
          got++;
        end
        if (cyc % (W + 2) == 0) begin
          a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); carryin = 1'($urandom);
          model(a, b, op_sub, carryin, es, ec, eo);
          qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
        end else begin
          a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); carryin = 1'($urandom);
        end
        @(negedge clk);
      end
      chk("b2b result count", got, 6);
      start = 1'b0;
      result_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
